vlane_shift_sched: RTL and testbench

Round-robin scheduler sharing one pipelined vector-lane barrel shifter (two-stage, one internal register) among NUMREQ requesters.
- Arbitrates requests and drives the shifter operands.
- Tracks in-flight operations by tag through the shifter latency.
- Buffers results in a credit-protected output FIFO so a stalled consumer never loses data.
- Sits between the lane's functional-unit issue ports and the shifter instance.

---
 rtl/vlane_shift_sched_if.sv | 33 +++
 rtl/vlane_shift_sched.sv | 146 ++++++++++++++
 tb/tb_vlane_shift_sched.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vlane_shift_sched_if.sv
// Bundle between the vector-lane issue ports, the shared shifter and the result consumer.
// slave = scheduler side, master = surrounding lane (requesters, shifter, consumer).
interface vlane_shift_sched_if #(
  parameter int NUMREQ    = 4,
  parameter int TAGW      = 2,
  parameter int WIDTH     = 32,
  parameter int LOG2WIDTH = 5
);
  logic [NUMREQ-1:0]           req_valid;
  logic [NUMREQ*WIDTH-1:0]     req_opB;
  logic [NUMREQ*LOG2WIDTH-1:0] req_sa;
  logic [NUMREQ*2-1:0]         req_op;
  logic [NUMREQ-1:0]           req_grant;
  logic [WIDTH-1:0]            sh_opB;
  logic [LOG2WIDTH-1:0]        sh_sa;
  logic [1:0]                  sh_op;
  logic [WIDTH-1:0]            sh_result;
  logic                        resp_valid;
  logic [TAGW-1:0]             resp_tag;
  logic [WIDTH-1:0]            resp_data;
  logic                        resp_ready;
  logic                        idle;

  modport slave (
    input  req_valid, req_opB, req_sa, req_op, sh_result, resp_ready,
    output req_grant, sh_opB, sh_sa, sh_op, resp_valid, resp_tag, resp_data, idle
  );

  modport master (
    output req_valid, req_opB, req_sa, req_op, sh_result, resp_ready,
    input  req_grant, sh_opB, sh_sa, sh_op, resp_valid, resp_tag, resp_data, idle
  );
endinterface

// File: rtl/vlane_shift_sched.sv
// Round-robin scheduler sharing one pipelined barrel shifter among NUMREQ requesters, with
// tag tracking and a credit-protected result FIFO. Perf counters: VLANE_SHIFT_SCHED_PERF_EN.
module vlane_shift_sched #(
  parameter int NUMREQ    = 4,
  parameter int TAGW      = 2,
  parameter int WIDTH     = 32,
  parameter int LOG2WIDTH = 5,
  parameter int LATENCY   = 1,
  parameter int FIFODEPTH = 3
) (
  input  logic clk,
  input  logic resetn,
`ifdef VLANE_SHIFT_SCHED_PERF_EN
  output logic [31:0] perf_issue,
  output logic [31:0] perf_stall,
`endif
  vlane_shift_sched_if.slave bus
);
  localparam int CNTW = $clog2(FIFODEPTH + 1);
  localparam int OCCW = CNTW + 1;

  logic [TAGW-1:0]                 ptr_q, ptr_d;
  logic [LATENCY-1:0]              pipe_vld_q, pipe_vld_d;
  logic [LATENCY-1:0][TAGW-1:0]    pipe_tag_q, pipe_tag_d;
  logic [FIFODEPTH-1:0][WIDTH-1:0] fdata_q, fdata_d;
  logic [FIFODEPTH-1:0][TAGW-1:0]  ftag_q, ftag_d;
  logic [CNTW-1:0]                 fcount_q, fcount_d;

  logic [NUMREQ-1:0] rot_valid_s;
  logic [NUMREQ-1:0] grant_s;
  logic [TAGW-1:0]   off_s, gidx_s;
  logic              gvld_s;
  logic [CNTW-1:0]   inflight_s;
  logic              credit_ok_s;
  logic              push_s, pop_s;
  int                widx_s;

  // Credits come only from registered occupancy, so a consumer pop never reaches the grant path.
  always_comb begin
    inflight_s = '0;
    for (int s = 0; s < LATENCY; s++) begin
      inflight_s = inflight_s + CNTW'(pipe_vld_q[s]);
    end
    credit_ok_s = (OCCW'(fcount_q) + OCCW'(inflight_s)) < OCCW'(FIFODEPTH);
  end

  // Rotate the request vector to start at ptr, pick the first set bit, then map back.
  always_comb begin
    rot_valid_s = '0;
    off_s       = '0;
    for (int k = 0; k < NUMREQ; k++) begin
      rot_valid_s[k] = bus.req_valid[(int'(ptr_q) + k) % NUMREQ];
    end
    for (int k = NUMREQ - 1; k >= 0; k--) begin
      off_s = rot_valid_s[k] ? TAGW'(k) : off_s;
    end
    gvld_s  = !resetn && credit_ok_s && (|rot_valid_s);
    gidx_s  = TAGW'((int'(ptr_q) + int'(off_s)) % NUMREQ);
    grant_s = gvld_s ? (NUMREQ'(1'b1) << gidx_s) : '0;
    if (gvld_s) begin
      ptr_d = (gidx_s == TAGW'(NUMREQ - 1)) ? '0 : gidx_s + 1'b1;
    end else begin
      ptr_d = ptr_q;
    end
  end

  assign bus.req_grant = grant_s;
  assign bus.sh_opB    = gvld_s ? bus.req_opB[int'(gidx_s)*WIDTH +: WIDTH] : '0;
  assign bus.sh_sa     = gvld_s ? bus.req_sa[int'(gidx_s)*LOG2WIDTH +: LOG2WIDTH] : '0;
  assign bus.sh_op     = gvld_s ? bus.req_op[int'(gidx_s)*2 +: 2] : 2'b00;

  // Tag pipe tracks the shifter latency; the FIFO shifts toward entry 0, which is the head.
  always_comb begin
    pipe_vld_d[0] = gvld_s;
    pipe_tag_d[0] = gidx_s;
    for (int s = 1; s < LATENCY; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
      pipe_tag_d[s] = pipe_tag_q[s-1];
    end
    push_s  = pipe_vld_q[LATENCY-1];
    pop_s   = (fcount_q != '0) && bus.resp_ready;
    widx_s  = int'(fcount_q) - (pop_s ? 1 : 0);
    fdata_d = fdata_q;
    ftag_d  = ftag_q;
    for (int i = 0; i < FIFODEPTH - 1; i++) begin
      fdata_d[i] = pop_s ? fdata_q[i+1] : fdata_q[i];
      ftag_d[i]  = pop_s ? ftag_q[i+1]  : ftag_q[i];
    end
    for (int i = 0; i < FIFODEPTH; i++) begin
      fdata_d[i] = (push_s && (i == widx_s)) ? bus.sh_result : fdata_d[i];
      ftag_d[i]  = (push_s && (i == widx_s)) ? pipe_tag_q[LATENCY-1] : ftag_d[i];
    end
    fcount_d = fcount_q + CNTW'(push_s) - CNTW'(pop_s);
  end

  // State registers; reset discards every in-flight and buffered result.
  always_ff @(posedge clk) begin
    if (resetn) begin
      ptr_q      <= '0;
      pipe_vld_q <= '0;
      pipe_tag_q <= '0;
      fdata_q    <= '0;
      ftag_q     <= '0;
      fcount_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_tag_q <= pipe_tag_d;
      fdata_q    <= fdata_d;
      ftag_q     <= ftag_d;
      fcount_q   <= fcount_d;
    end
  end

  assign bus.resp_valid = (fcount_q != '0);
  assign bus.resp_tag   = ftag_q[0];
  assign bus.resp_data  = fdata_q[0];
  assign bus.idle       = (inflight_s == '0) && (fcount_q == '0);

`ifdef VLANE_SHIFT_SCHED_PERF_EN
  logic [31:0] perf_issue_q, perf_issue_d, perf_stall_q, perf_stall_d;

  // Free-running event counters, wrapping naturally at 2^32.
  always_comb begin
    perf_issue_d = perf_issue_q + 32'(gvld_s);
    perf_stall_d = perf_stall_q + 32'((|bus.req_valid) && !credit_ok_s);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (resetn) begin
      perf_issue_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_issue = perf_issue_q;
  assign perf_stall = perf_stall_q;
`endif

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (resetn)
    !(push_s && (fcount_q == CNTW'(FIFODEPTH))));
endmodule

// File: tb/tb_vlane_shift_sched.sv
// Directed bench for vlane_shift_sched: models the one-register shifter and scoreboards
// every accepted request against the response stream.
module tb_vlane_shift_sched;
  localparam int NUMREQ = 4, TAGW = 2, WIDTH = 32, LOG2WIDTH = 5;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  vlane_shift_sched_if #(.NUMREQ(NUMREQ), .TAGW(TAGW), .WIDTH(WIDTH), .LOG2WIDTH(LOG2WIDTH)) bus ();

`ifdef VLANE_SHIFT_SCHED_PERF_EN
  logic [31:0] perf_issue, perf_stall;
  logic [31:0] stall_base;
`endif

  vlane_shift_sched dut (
    .clk       (clk),
    .resetn    (resetn),
`ifdef VLANE_SHIFT_SCHED_PERF_EN
    .perf_issue(perf_issue),
    .perf_stall(perf_stall),
`endif
    .bus       (bus)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_acc = 0;
  logic [TAGW+WIDTH-1:0] sbq[$];
  logic [NUMREQ-1:0] last_grant = '0;
  logic [WIDTH-1:0] sh_res_q;

  function automatic logic [31:0] ref_shift(input logic [31:0] b, input logic [4:0] sa, input logic [1:0] op);
    case (op)
      2'b01:   return b >> sa;
      2'b11:   return 32'($signed(b) >>> sa);
      default: return b << sa;
    endcase
  endfunction

  // Shifter model: one internal register between operands and result.
  always_ff @(posedge clk) sh_res_q <= ref_shift(bus.sh_opB, bus.sh_sa, bus.sh_op);
  assign bus.sh_result = sh_res_q;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  task automatic set_req(input int i, input logic [31:0] b, input logic [4:0] sa, input logic [1:0] op);
    bus.req_opB[i*WIDTH +: WIDTH] = b;
    bus.req_sa[i*LOG2WIDTH +: LOG2WIDTH] = sa;
    bus.req_op[i*2 +: 2] = op;
  endtask

  task automatic rand_req(input int i);
    int r;
    r = $urandom_range(0, 2);
    set_req(i, $urandom(), 5'($urandom_range(0, 31)), (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11);
  endtask

  // Negedge sample: pop/compare the head on a handshake, push expectations for accepts.
  task automatic sample();
    logic [TAGW+WIDTH-1:0] e;
    @(negedge clk);
    last_grant = bus.req_grant;
    check("grant_onehot", 32'($onehot0(bus.req_grant)), 32'd1);
    if (!resetn && bus.resp_valid && bus.resp_ready) begin
      check("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("resp_tag", 32'(bus.resp_tag), 32'(e[TAGW+WIDTH-1:WIDTH]));
        check("resp_data", bus.resp_data, e[WIDTH-1:0]);
      end
    end
    for (int i = 0; i < NUMREQ; i++) begin
      if (bus.req_valid[i] && bus.req_grant[i]) begin
        n_acc++;
        sbq.push_back({TAGW'(i), ref_shift(bus.req_opB[i*WIDTH +: WIDTH],
                       bus.req_sa[i*LOG2WIDTH +: LOG2WIDTH], bus.req_op[i*2 +: 2])});
      end
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUMREQ; i++) if (last_grant[i]) rand_req(i);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    sample();
    while (!bus.idle && k < 20) begin
      next();
      sample();
      k++;
    end
    check(name, 32'(bus.idle), 32'd1);
    check({name, "_sb_empty"}, 32'(sbq.size()), 32'd0);
    next();
  endtask

  task automatic one_op(input string name, input logic [31:0] b, input logic [4:0] sa,
                        input logic [1:0] op, input logic [31:0] expd);
    set_req(1, b, sa, op);
    bus.req_valid = 4'b0010;
    sample();
    check({name, "_grant"}, 32'(bus.req_grant), 32'h2);
    next();
    bus.req_valid = '0;
    sample();
    next();
    sample();
    check({name, "_valid"}, 32'(bus.resp_valid), 32'd1);
    check({name, "_data"}, bus.resp_data, expd);
    next();
    drain({name, "_idle"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_opB = '0;
    bus.req_sa = '0;
    bus.req_op = '0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < NUMREQ; i++) rand_req(i);

    // Reset values with requests pending: nothing may be granted.
    next();
    next();
    sample();
    check("rst_grant", 32'(bus.req_grant), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_tag", 32'(bus.resp_tag), 32'd0);
    check("rst_resp_data", bus.resp_data, 32'd0);
    check("rst_idle", 32'(bus.idle), 32'd1);
`ifdef VLANE_SHIFT_SCHED_PERF_EN
    check("rst_perf_issue", perf_issue, 32'd0);
    check("rst_perf_stall", perf_stall, 32'd0);
`endif
    next();
    resetn = 1'b0;
    bus.req_valid = '0;

    // Single op: requester 2, SRA by 4, response two cycles later.
    set_req(2, 32'h8000_0000, 5'd4, 2'b11);
    bus.req_valid = 4'b0100;
    sample();
    check("single_grant", 32'(bus.req_grant), 32'h4);
    next();
    bus.req_valid = '0;
    sample();
    check("single_c1_valid", 32'(bus.resp_valid), 32'd0);
    check("single_c1_idle", 32'(bus.idle), 32'd0);
    next();
    sample();
    check("single_c2_valid", 32'(bus.resp_valid), 32'd1);
    check("single_c2_tag", 32'(bus.resp_tag), 32'd2);
    check("single_c2_data", bus.resp_data, 32'hF800_0000);
    next();
    sample();
    check("single_idle", 32'(bus.idle), 32'd1);
    next();

    // Pointer wrap: ptr sits at 3, only requesters 3 and 0 valid.
    bus.req_valid = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      sample();
      check("wrap_grant", 32'(bus.req_grant), (c == 1) ? 32'h1 : 32'h8);
      next();
    end
    bus.req_valid = '0;
    drain("wrap_idle");

    // Shift operations and boundaries.
    one_op("sll31", 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
    one_op("srl31", 32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001);
    one_op("sra31", 32'h8000_0000, 5'd31, 2'b11, 32'hFFFF_FFFF);
    one_op("sra0",  32'h1234_5678, 5'd0,  2'b11, 32'h1234_5678);
    one_op("srl4",  32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000);

    // Contention from reset: round robin, one accept per cycle.
    resetn = 1'b1;
    sbq.delete();
    bus.req_valid = 4'b1111;
    next();
    resetn = 1'b0;
    for (int c = 0; c < 12; c++) begin
      sample();
      check("rr_grant", 32'(bus.req_grant), 32'(1) << (c % NUMREQ));
      if (c >= 2) begin
        check("rr_resp_valid", 32'(bus.resp_valid), 32'd1);
        check("rr_resp_tag", 32'(bus.resp_tag), 32'((c - 2) % NUMREQ));
      end
      next();
    end
    bus.req_valid = '0;
    drain("rr_idle");

    // Backpressure: three credits, then stall until the consumer drains.
    bus.resp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    n_acc = 0;
    for (int c = 0; c < 6; c++) begin
      sample();
      if (c >= 3) check("bp_blocked_grant", 32'(bus.req_grant), 32'd0);
`ifdef VLANE_SHIFT_SCHED_PERF_EN
      if (c == 3) stall_base = perf_stall;
      if (c == 5) check("bp_perf_stall", perf_stall, stall_base + 32'd2);
`endif
      next();
    end
    check("bp_accepts", 32'(n_acc), 32'd3);
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      sample();
      next();
    end
    check("bp_resume", 32'(n_acc > 3), 32'd1);
    bus.req_valid = '0;
    drain("bp_idle");

    // Reset mid-flight: two accepted ops vanish, pointer returns to 0.
    bus.resp_ready = 1'b0;
    bus.req_valid = 4'b0110;
    sample();
    check("mid_grant0", 32'(bus.req_grant), 32'h2);
    next();
    sample();
    check("mid_grant1", 32'(bus.req_grant), 32'h4);
    next();
    resetn = 1'b1;
    bus.req_valid = '0;
    sbq.delete();
    sample();
    next();
    resetn = 1'b0;
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sample();
      check("mid_no_resp", 32'(bus.resp_valid), 32'd0);
      check("mid_idle", 32'(bus.idle), 32'd1);
      next();
    end
    bus.req_valid = 4'b1010;
    sample();
    check("mid_ptr_reset", 32'(bus.req_grant), 32'h2);
    next();
    bus.req_valid = '0;
    drain("mid_final_idle");

    check("final_sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
